// File: rtl/reg_file_ba.sv
// Dual-read, single-write register file with base-address read gating,
// optional write-to-read bypass and a sequential scrub engine that zeroes every register.
module reg_file_ba #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 16,
   parameter int AW     = 4,
   parameter bit BYPASS = 1
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    ra_addr,
   input  logic [AW-1:0]    rb_addr,
   input  logic             ba_out,
   input  logic             scrub_req,
   output logic [WIDTH-1:0] ra_data,
   output logic [WIDTH-1:0] rb_data,
   output logic             busy,
   output logic             wr_drop
);

   typedef enum logic {IDLE, SCRUB} state_t;

   state_t           state;
   logic [AW-1:0]    scrub_idx;
   logic [WIDTH-1:0] regs [DEPTH];

   logic             fwd_ok;
   logic [AW-1:0]    last_idx;

   assign last_idx = AW'(DEPTH - 1);

   // Writes are only honoured while idle; a scrub walks scrub_idx once from 0 to DEPTH-1.
   always_ff @(posedge clk) begin
      if (!clr) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         state     <= IDLE;
         scrub_idx <= '0;
         busy      <= 1'b0;
         wr_drop   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               wr_drop <= 1'b0;
               if (wr_en) regs[wr_addr] <= wr_data;
               if (scrub_req) begin
                  state     <= SCRUB;
                  scrub_idx <= '0;
                  busy      <= 1'b1;
               end
            end
            SCRUB: begin
               regs[scrub_idx] <= '0;
               wr_drop         <= wr_en;
               if (scrub_idx == last_idx) begin
                  state     <= IDLE;
                  scrub_idx <= '0;
                  busy      <= 1'b0;
               end else begin
                  scrub_idx <= scrub_idx + AW'(1);
               end
            end
            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               wr_drop <= 1'b0;
            end
         endcase
      end
   end

   assign fwd_ok = BYPASS && !busy && wr_en;

   // Base-address gating beats forwarding, which beats stored contents.
   always_comb begin
      ra_data = regs[ra_addr];
      if (fwd_ok && (wr_addr == ra_addr)) ra_data = wr_data;
      if (ba_out && (ra_addr == '0))      ra_data = '0;

      rb_data = regs[rb_addr];
      if (fwd_ok && (wr_addr == rb_addr)) rb_data = wr_data;
      if (ba_out && (rb_addr == '0))      rb_data = '0;
   end

endmodule

// File: tb/tb_reg_file_ba.sv
// Self-checking bench for reg_file_ba: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the register file.
module tb_reg_file_ba;

   localparam int W = 32;
   localparam int D = 16;
   localparam int A = 4;

   logic         clk = 1'b0;
   logic         clr;
   logic         wr_en;
   logic [A-1:0] wr_addr;
   logic [W-1:0] wr_data;
   logic [A-1:0] ra_addr;
   logic [A-1:0] rb_addr;
   logic         ba_out;
   logic         scrub_req;
   logic [W-1:0] ra_data;
   logic [W-1:0] rb_data;
   logic         busy;
   logic         wr_drop;

   int checks = 0;
   int fails  = 0;

   logic [W-1:0] mem [D];
   int           scrubLeft;
   int           scrubIdx;
   logic         expDrop;

   always #5 clk = ~clk;

   reg_file_ba #(.WIDTH(W), .DEPTH(D), .AW(A), .BYPASS(1)) dut (
      .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .ra_addr(ra_addr), .rb_addr(rb_addr), .ba_out(ba_out), .scrub_req(scrub_req),
      .ra_data(ra_data), .rb_data(rb_data), .busy(busy), .wr_drop(wr_drop)
   );

   task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] expRead(input logic [A-1:0] a);
      if (ba_out && a == '0) return '0;
      if (scrubLeft == 0 && wr_en && wr_addr == a) return wr_data;
      return mem[a];
   endfunction

   // Drive one cycle's inputs at the falling edge, then compare every output to the model.
   task automatic applyStimulus(input logic c, input logic we, input logic [A-1:0] wa,
                                input logic [W-1:0] wd, input logic [A-1:0] a,
                                input logic [A-1:0] b, input logic ba, input logic sr);
      @(negedge clk);
      clr = c; wr_en = we; wr_addr = wa; wr_data = wd;
      ra_addr = a; rb_addr = b; ba_out = ba; scrub_req = sr;
      #1;
      checkOutput("ra_data", ra_data, expRead(ra_addr));
      checkOutput("rb_data", rb_data, expRead(rb_addr));
      checkOutput("busy", W'(busy), W'(scrubLeft > 0));
      checkOutput("wr_drop", W'(wr_drop), W'(expDrop));
   endtask

   // Advance the model across the rising edge using the inputs held for this cycle.
   task automatic tick();
      @(posedge clk);
      if (!clr) begin
         for (int i = 0; i < D; i++) mem[i] = '0;
         scrubLeft = 0;
         scrubIdx  = 0;
         expDrop   = 1'b0;
      end else if (scrubLeft > 0) begin
         mem[scrubIdx] = '0;
         scrubIdx++;
         scrubLeft--;
         expDrop = wr_en;
      end else begin
         if (wr_en) mem[wr_addr] = wr_data;
         expDrop = 1'b0;
         if (scrub_req) begin
            scrubLeft = D;
            scrubIdx  = 0;
         end
      end
   endtask

   task automatic idle(input logic [A-1:0] a, input logic [A-1:0] b);
      applyStimulus(1'b1, 1'b0, '0, '0, a, b, 1'b0, 1'b0);
   endtask

   initial begin
      int busyCnt;
      int dropCnt;
      bit seenBusy;

      clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      ra_addr = '0; rb_addr = '0; ba_out = 1'b0; scrub_req = 1'b0;
      repeat (2) @(posedge clk);
      for (int i = 0; i < D; i++) mem[i] = '0;
      scrubLeft = 0; scrubIdx = 0; expDrop = 1'b0;

      idle(4'd5, 4'd0);
      checkOutput("reset_ra", ra_data, 32'h0);
      checkOutput("reset_busy", W'(busy), 32'h0);
      tick();

      applyStimulus(1'b1, 1'b1, 4'd5, 32'hDEADBEEF, 4'd1, 4'd2, 1'b0, 1'b0);
      tick();
      idle(4'd5, 4'd5);
      checkOutput("write5", ra_data, 32'hDEADBEEF);
      tick();

      applyStimulus(1'b1, 1'b1, 4'd0, 32'h00001234, 4'd5, 4'd6, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, '0, '0, 4'd0, 4'd0, 1'b0, 1'b0);
      checkOutput("reg0_a", ra_data, 32'h00001234);
      checkOutput("reg0_b", rb_data, 32'h00001234);
      tick();
      applyStimulus(1'b1, 1'b0, '0, '0, 4'd0, 4'd0, 1'b1, 1'b0);
      checkOutput("ba_a", ra_data, 32'h0);
      checkOutput("ba_b", rb_data, 32'h0);
      tick();

      applyStimulus(1'b1, 1'b1, 4'd3, 32'hA5A5A5A5, 4'd3, 4'd5, 1'b0, 1'b0);
      checkOutput("bypass", ra_data, 32'hA5A5A5A5);
      checkOutput("no_bypass_b", rb_data, 32'hDEADBEEF);
      tick();
      applyStimulus(1'b1, 1'b1, 4'd0, 32'h00000077, 4'd0, 4'd3, 1'b1, 1'b0);
      checkOutput("ba_over_bypass", ra_data, 32'h0);
      tick();

      for (int k = 0; k < D; k++) begin
         applyStimulus(1'b1, 1'b1, A'(k), 32'hFFFFFFFF, A'(k), A'(k + 1), 1'b0, 1'b0);
         tick();
      end
      applyStimulus(1'b1, 1'b0, '0, '0, 4'd7, 4'd15, 1'b0, 1'b1);
      tick();

      busyCnt = 0; dropCnt = 0; seenBusy = 0;
      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'b1, i == 3, 4'd7, 32'h00000055, A'(i + 15), A'(i), 1'b0, i == 5);
         if (busy) begin
            busyCnt++;
            seenBusy = 1;
         end
         if (wr_drop) dropCnt++;
         tick();
         if (seenBusy && !busy) break;
      end
      checkOutput("busy_len", W'(busyCnt), 32'd16);
      checkOutput("drop_pulses", W'(dropCnt), 32'd1);
      for (int k = 0; k < D; k++) begin
         idle(A'(k), A'(15 - k));
         checkOutput("post_scrub", ra_data, 32'h0);
         tick();
      end

      for (int k = 0; k < D; k++) begin
         applyStimulus(1'b1, 1'b1, A'(k), $urandom | 32'h1, 4'd0, 4'd1, 1'b0, 1'b0);
         tick();
      end
      applyStimulus(1'b1, 1'b0, '0, '0, 4'd2, 4'd3, 1'b0, 1'b1);
      tick();
      for (int i = 0; i < 8; i++) begin
         idle(A'(i), A'(15 - i));
         tick();
      end
      applyStimulus(1'b0, 1'b1, 4'd9, 32'h12345678, 4'd9, 4'd14, 1'b0, 1'b1);
      tick();
      for (int k = 0; k < D; k++) begin
         idle(A'(k), A'(k));
         checkOutput("abort_zero", ra_data, 32'h0);
         checkOutput("abort_busy", W'(busy), 32'h0);
         tick();
      end
      applyStimulus(1'b1, 1'b0, '0, '0, 4'd1, 4'd2, 1'b0, 1'b1);
      tick();
      idle(4'd1, 4'd2);
      checkOutput("rescrub_busy", W'(busy), 32'h1);
      tick();
      repeat (20) begin
         idle(4'd0, 4'd1);
         tick();
      end

      for (int i = 0; i < 500; i++) begin
         applyStimulus($urandom_range(0, 59) != 0, 1'($urandom), A'($urandom), $urandom,
                       A'($urandom), A'($urandom), $urandom_range(0, 3) == 0,
                       $urandom_range(0, 39) == 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
